// File: rtl/mux8_seq_pkg.sv
// ---------------------------------------------------------------------------
// mux8_seq_pkg : shared state encoding and sizes for the mux8 select sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mux8_seq_pkg;

  localparam int N_IN  = 8;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_LAST = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mux8_seq_step_timer.sv
// ---------------------------------------------------------------------------
// mux8_seq_step_timer : hold counter, pulses step_end on the last held cycle
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux8_seq_step_timer
  import mux8_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic step_end
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last  = (cnt == CNT_LAST);
  assign step_end = enable && at_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      // Wraps to zero on its own so the next select step starts fresh.
      cnt <= at_last ? '0 : cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux8_sel_sequencer.sv
// ---------------------------------------------------------------------------
// mux8_sel_sequencer : loads a word onto the mux inputs, sweeps select 0..7 and
// serialises Y. Optional compare of Y against d[s] under MUX8_SEQ_SELF_CHECK_EN.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux8_sel_sequencer
  import mux8_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [N_IN-1:0]  load_data,
  input  logic             abort,
  output logic [N_IN-1:0]  d,
  output logic [SEL_W-1:0] s,
  input  logic             y_in,
  output logic             busy,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done,
  output logic             mismatch
);

  state_t state;
  logic   step_end;
  logic   timer_en;
  logic   load_fire;

  assign load_ready = (state == IDLE);
  assign busy       = (state == RUN);
  assign load_fire  = load_valid && load_ready;
  // abort stalls the timer so it can never produce a sample in the same cycle.
  assign timer_en   = (state == RUN) && !abort;

  mux8_seq_step_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!timer_en),
    .enable   (timer_en),
    .step_end (step_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      d         <= '0;
      s         <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            d     <= load_data;
            s     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            s     <= '0;
          end else if (step_end) begin
            bit_out   <= y_in;
            bit_valid <= 1'b1;
            if (s == SEL_LAST) begin
              state <= IDLE;
              s     <= '0;
              done  <= 1'b1;
            end else begin
              s <= s + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUX8_SEQ_SELF_CHECK_EN
  // Sticky until the next accepted load; set on the same edge as bit_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch <= 1'b0;
    end else if (load_fire) begin
      mismatch <= 1'b0;
    end else if (timer_en && step_end && (d[s] != y_in)) begin
      mismatch <= 1'b1;
    end
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux8_sel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux8_sel_sequencer : scoreboard bench, one H=1 and one H=3 instance each
// driven by an ideal mux model. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mux8_sel_sequencer;

`ifdef MUX8_SEQ_SELF_CHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  typedef struct {
    logic b;
    logic dn;
    logic mm;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  logic       lv_a, lr_a, ab_a, y_a, busy_a, bo_a, bv_a, dn_a, mm_a, inj_a;
  logic [7:0] ld_a, d_a;
  logic [2:0] s_a;
  logic       lv_b, lr_b, ab_b, y_b, busy_b, bo_b, bv_b, dn_b, mm_b;
  logic [7:0] ld_b, d_b;
  logic [2:0] s_b;

  assign y_a = d_a[s_a] ^ (inj_a && (s_a == 3'd5));
  assign y_b = d_b[s_b];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux8_sel_sequencer #(.HOLD_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_valid(lv_a), .load_ready(lr_a),
    .load_data(ld_a), .abort(ab_a), .d(d_a), .s(s_a), .y_in(y_a),
    .busy(busy_a), .bit_out(bo_a), .bit_valid(bv_a), .done(dn_a),
    .mismatch(mm_a)
  );

  mux8_sel_sequencer #(.HOLD_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_valid(lv_b), .load_ready(lr_b),
    .load_data(ld_b), .abort(ab_b), .d(d_b), .s(s_b), .y_in(y_b),
    .busy(busy_b), .bit_out(bo_b), .bit_valid(bv_b), .done(dn_b),
    .mismatch(mm_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit inst, input logic [7:0] w, input int t,
                      input int h, input int n, input bit inj);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.b   = w[k] ^ (inj && (k == 5));
      e.cyc = t + (k + 1) * h + 1;
      e.dn  = (k == 7);
      e.mm  = SC && inj && (k >= 5);
      if (inst) qb.push_back(e);
      else      qa.push_back(e);
    end
  endtask

  task automatic load_a(input logic [7:0] w, input bit inj, input int n, output int t);
    tick();
    lv_a = 1'b1; ld_a = w; inj_a = inj;
    @(negedge clk);
    t = cyc;
    check("a_load_ready", lr_a, 1'b1);
    push(1'b0, w, t, 1, n, inj);
    tick();
    lv_a = 1'b0;
  endtask

  task automatic drain_a(input int max_cycles);
    for (int i = 0; i < max_cycles && qa.size() != 0; i++) @(negedge clk);
    check("a_drain", qa.size(), 0);
  endtask

  task automatic drain_b(input int max_cycles);
    for (int i = 0; i < max_cycles && qb.size() != 0; i++) @(negedge clk);
    check("b_drain", qb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bv_a) begin
        check("a_bit_expected", qa.size() != 0, 1'b1);
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          check("a_bit", bo_a, ea.b);
          check("a_bit_cycle", cyc, ea.cyc);
          check("a_done", dn_a, ea.dn);
          check("a_mismatch", mm_a, ea.mm);
        end
      end else if (dn_a) begin
        check("a_stray_done", dn_a, 1'b0);
      end
      if (bv_b) begin
        check("b_bit_expected", qb.size() != 0, 1'b1);
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          check("b_bit", bo_b, eb.b);
          check("b_bit_cycle", cyc, eb.cyc);
          check("b_done", dn_b, eb.dn);
        end
      end else if (dn_b) begin
        check("b_stray_done", dn_b, 1'b0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, k;
    bit found;
    rst_n = 1'b0;
    lv_a = 1'b0; ld_a = '0; ab_a = 1'b0; inj_a = 1'b0;
    lv_b = 1'b0; ld_b = '0; ab_b = 1'b0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_d", d_a, 8'h00);
    check("rst_s", s_a, 3'd0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_bit_out", bo_a, 1'b0);
    check("rst_bit_valid", bv_a, 1'b0);
    check("rst_done", dn_a, 1'b0);
    check("rst_mismatch", mm_a, 1'b0);
    check("rst_load_ready", lr_a, 1'b1);
    check("rst_b_s", s_b, 3'd0);
    check("rst_b_load_ready", lr_b, 1'b1);
    tick();
    rst_n = 1'b1;

    // H=1 frame, word 1001_0110
    load_a(8'b1001_0110, 1'b0, 8, t);
    @(negedge clk);
    check("a_busy_first", busy_a, 1'b1);
    check("a_s_first", s_a, 3'd0);
    check("a_d_loaded", d_a, 8'b1001_0110);
    check("a_load_ready_busy", lr_a, 1'b0);
    while (cyc < t + 8) @(negedge clk);
    check("a_busy_last", busy_a, 1'b1);
    check("a_s_last", s_a, 3'd7);
    @(negedge clk);
    check("a_busy_after", busy_a, 1'b0);
    check("a_ready_after", lr_a, 1'b1);
    check("a_s_after", s_a, 3'd0);
    drain_a(5);

    // H=3 frame, same word
    tick();
    lv_b = 1'b1; ld_b = 8'b1001_0110;
    @(negedge clk);
    t = cyc;
    check("b_load_ready", lr_b, 1'b1);
    push(1'b1, 8'b1001_0110, t, 3, 8, 1'b0);
    tick();
    lv_b = 1'b0;
    for (k = 0; k < 24; k++) begin
      @(negedge clk);
      check("b_sel_hold", s_b, k / 3);
    end
    drain_b(5);

    // Abort during step 3; load offered while busy must be ignored
    load_a(8'hA5, 1'b0, 3, t);
    lv_a = 1'b1; ld_a = 8'h3C;
    tick();
    tick();
    lv_a = 1'b0;
    tick();
    ab_a = 1'b1;
    tick();
    ab_a = 1'b0;
    @(negedge clk);
    check("abort_cycle", cyc, t + 5);
    check("abort_s", s_a, 3'd0);
    check("abort_ready", lr_a, 1'b1);
    check("abort_busy", busy_a, 1'b0);
    check("abort_d_held", d_a, 8'hA5);
    repeat (4) @(negedge clk);
    check("abort_bits_left", qa.size(), 0);

    // Back-to-back loads with load_valid held high
    tick();
    lv_a = 1'b1; ld_a = 8'hFF;
    @(negedge clk);
    t = cyc;
    push(1'b0, 8'hFF, t, 1, 8, 1'b0);
    tick();
    ld_a = 8'h00;
    found = 1'b0;
    t2 = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (lr_a) begin
        found = 1'b1;
        t2 = cyc;
      end
    end
    check("b2b_ready_seen", found, 1'b1);
    check("b2b_accept_cycle", t2, t + 9);
    push(1'b0, 8'h00, t2, 1, 8, 1'b0);
    tick();
    lv_a = 1'b0;
    drain_a(20);

    // Corrupted Y on step 5, then a clean load clears the flag
    load_a(8'h5A, 1'b1, 8, t);
    drain_a(15);
    @(negedge clk);
    check("mm_sticky_after_done", mm_a, SC);
    load_a(8'h0F, 1'b0, 8, t);
    @(negedge clk);
    check("mm_cleared_on_load", mm_a, 1'b0);
    drain_a(15);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux8_sel_sequencer.md
# mux8_sel_sequencer

Sequencer that sits directly upstream of the lab's 8-to-1 multiplexer. It accepts an 8-bit data word over a valid/ready handshake and drives that word onto the mux's eight data inputs. It then steps the 3-bit select through indices 0..7 and samples the mux output Y once per step, producing a serial bit stream. This turns the hand-written stimulus sweep into a reusable clocked stage.

## Interface
Parameters:
- HOLD_CYCLES, default 1: clock cycles each select value is held; legal range 1..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- load_valid  in  1  a data word is offered.
- load_ready  out  1  high exactly when state is IDLE.
- load_data  in  8  word; bit k is the mux data input selected by index k.
- abort  in  1  cancels a frame in progress.
- d  out  8  registered word to mux data inputs (d[0]→D000 … d[7]→D111).
- s  out  3  select, index = s; s[0]→S0, s[1]→S1, s[2]→S2.
- y_in  in  1  mux output Y, combinational return.
- busy  out  1  high in RUN.
- bit_out  out  1  sampled Y.
- bit_valid  out  1  one-cycle pulse qualifying bit_out.
- done  out  1  one-cycle pulse on completion of a full frame.
- mismatch  out  1  self-check flag (see Configuration).

## Operation
- States: IDLE, RUN. Reset → IDLE; d=0, s=0, busy=0, bit_out=0, bit_valid=0, done=0, mismatch=0. load_ready=1 whenever in IDLE.
- IDLE: on load_valid & load_ready → d<=load_data, s<=0, hold counter<=0, state<=RUN. abort is ignored in IDLE.
- RUN: the hold counter counts 0..HOLD_CYCLES-1.
  - On its last count, y_in is sampled into bit_out and bit_valid pulses on the next cycle.
  - If s≠7, s increments and the counter clears.
  - If s=7, state<=IDLE, s<=0, and done pulses together with the final bit_valid.
- Bits leave in index order 0→7. s never wraps past 7 within a frame.
- abort in RUN has priority over sampling. Next cycle: IDLE, s=0, no bit_valid, no done. d holds its value.
- Reset mid-frame: same as abort, and all outputs are forced to their reset values.
- d holds the last word while in IDLE. It changes only on an accepted load.

## Timing
- Load accepted at cycle T; first RUN cycle is T+1.
- Step k occupies cycles T+1+k·H … T+(k+1)·H, where H=HOLD_CYCLES. y_in is sampled in the last of those cycles.
- bit_valid for step k is at cycle T+(k+1)·H+1. done is at T+8H+1.
- With H=1: bit_valid at T+2..T+9, done at T+9.
- load_ready rises at T+8H+1. A back-to-back load accepted there starts RUN at T+8H+2, giving one idle cycle between frames.
- y_in must settle within one cycle of s/d changing. With H=1 the sample uses the same cycle's s.

## Configuration
- MUX8_SEQ_SELF_CHECK_EN defined:
  - On each sample, the expected bit d[s] is compared with y_in.
  - mismatch is registered alongside bit_valid and is sticky until the next accepted load or reset.
- Not defined: the compare logic is absent and mismatch is tied to 0. All other behaviour is identical.

## Structure
- Package mux8_seq_pkg holds:
  - state enum {IDLE, RUN};
  - localparams N_IN=8, SEL_W=3, SEL_LAST=3'd7.
- Sub-module mux8_seq_step_timer holds the hold counter. Its width is max(1, $clog2(HOLD_CYCLES)). Inputs: clear and enable. Output: a step_end pulse.
- Top level contains the FSM, the select register, the d register, and the optional check.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles → all outputs 0, load_ready=1, s=0.
- Load 8'b1001_0110, H=1, with an ideal mux model on d/s/y_in → bits 0,1,1,0,1,0,0,1 at T+2..T+9, done at T+9, busy high T+1..T+8.
- H=3, same word → s holds each value for 3 cycles, bit_valid at T+4, T+7 … T+25, done at T+25.
- abort asserted at T+4, H=1 → exactly 3 bit_valid pulses, no done, s=0 and load_ready=1 at T+5. load_valid while busy is not accepted.
- Back-to-back loads 8'hFF then 8'h00 with load_valid held high → second accepted at T+9, 16 bits total, done at T+9 and T+18.
- With MUX8_SEQ_SELF_CHECK_EN: force y_in inverted on step 5 → mismatch rises with the 6th bit_valid, stays high through done, clears on the next accepted load.
